inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the byte-addressable instruction memory. Drives the memory PC,
//  captures each combinationally-read 32-bit word into a one-entry output register,
//  and hands it to decode over a valid/ready handshake.
//  Supports stall (decode back-pressure), redirect (branch/jump) with flush,
//  and halting at end of program.
// PARAMETERS
//  ADDR_W     32  width of all PC values
//  RESET_PC   0   first fetch address after start
//  MEM_BYTES  24  instruction memory size in bytes; valid PCs are 0..MEM_BYTES-4
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       synchronous, active-low
//  start          in   1       begin fetching; sampled only in IDLE
//  redirect_valid in   1       load redirect_pc and flush the output slot
//  redirect_pc    in   ADDR_W  redirect target byte address
//  mem_pc         out  ADDR_W  address to instruction memory (registered)
//  mem_instr      in   32      word from memory at mem_pc, same cycle
//  instr_valid    out  1       instr/instr_pc hold an unconsumed word
//  instr_ready    in   1       decode accepts the word when instr_valid && instr_ready
//  instr          out  32      fetched instruction
//  instr_pc       out  ADDR_W  address of instr
//  halted         out  1       program finished; sticky until reset
//  fetch_err      out  1       bad redirect target; sticky until reset
// BEHAVIOUR
//  - Clock/reset: reset reset, synchronous, active-low; clock clock.
//  - Reset (reset==0 at an edge, in any state, including mid-fetch):
//    state=IDLE, mem_pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_err=0.
//  - States: IDLE, FETCH, STALL, DRAIN, DONE.
//  - IDLE: start=1 -> FETCH. redirect_valid is ignored.
//  - FETCH: slot free means !instr_valid or (instr_valid && instr_ready).
//    - mem_pc<=MEM_BYTES-4 and slot free: instr<=mem_instr, instr_pc<=mem_pc,
//      instr_valid<=1, mem_pc<=mem_pc+4.
//    - Slot not free: -> STALL. Outputs and mem_pc are held stable.
//    - mem_pc>MEM_BYTES-4: no capture. -> DRAIN if instr_valid && !instr_ready.
//      Otherwise instr_valid<=0 and -> DONE.
//  - STALL: instr_ready=1 -> perform the FETCH capture in the same edge, then -> FETCH.
//  - DRAIN: instr_ready=1 -> instr_valid<=0, -> DONE.
//  - DONE: halted=1, instr_valid=0. Exit only via reset.
//  - Redirect (FETCH/STALL/DRAIN) takes priority over capture:
//    instr_valid<=0 (flush), mem_pc<=redirect_pc, -> FETCH.
//    - A handshake in the same cycle still counts as accepted; only the next word is dropped.
//    - redirect_pc[1:0]!=0 or redirect_pc>MEM_BYTES-4: fetch_err<=1, halted<=1, -> DONE.
//  - Latency: start at edge t -> FETCH at t+1 -> instr_valid=1 at t+2.
//    Steady state is 1 word/cycle with instr_ready held high.
//  - mem_pc increments by exactly 4 per capture, is ADDR_W wide, and never wraps.
//    The end check prevents overflow.
//  - start while not in IDLE is ignored. fetch_err and halted never deassert before reset.
// STRUCTURE
//  - Shared package fetch_pkg: state encoding (3-bit localparams), INSTR_BYTES=4,
//    and the end-of-program / alignment check as a constant function.
//  - One natural sub-module: fetch_out_slot.
//    - One-entry valid/ready output register with load, flush and hold.
//    - Exports slot_free.
//  - Top holds the FSM and the mem_pc register.
// TESTING
//  Memory preloaded: 0x00=0x00940333, 0x04=0x412983b3, 0x08=0x00f768b3,
//  0x0C=0x00d67fb3, 0x10=0x017b4e33, 0x14=0x01bdaf33.
//  1. Reset, start=1 for 1 cycle, ready=1
//     -> six words in order, pc 0x00..0x14, 1/cycle.
//     halted=1 the cycle after the 0x14 handshake; instr_valid=0 thereafter.
//  2. ready=0 for 3 cycles while holding 0x412983b3@0x04
//     -> instr/instr_pc/mem_pc stable. Release -> 0x00f768b3@0x08 next.
//  3. redirect_valid, redirect_pc=0x10 while 0x04 word valid
//     -> next cycle instr_valid=0; then 0x017b4e33@0x10, 0x01bdaf33@0x14, halted.
//  4. redirect_pc=0x06 -> fetch_err=1, halted=1, instr_valid=0.
//     redirect_pc=0x18 (separate run) -> same response.
//  5. ready=0 when the last word 0x01bdaf33 is presented -> DRAIN, halted=0.
//     ready=1 -> halted=1 next cycle.
//  6. reset=0 mid-stream at pc 0x0C -> all outputs at reset values next edge.
//     start -> fetching resumes from 0x00.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// instruction size and the fetch-address legality check.
package fetch_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_STALL = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_FETCH = S_FETCH,
    ST_STALL = S_STALL,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  // A PC is fetchable when word-aligned and no later than the last word slot.
  function automatic logic pc_ok(input logic [63:0] pc, input logic [63:0] last_pc);
    return (pc <= last_pc) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Memory address/data and decode hand-off signals of the fetch sequencer.
// instr_valid/instr_ready: a word transfers on every rising edge where both are 1;
// while instr_valid=1 and instr_ready=0 the master holds instr and instr_pc stable.
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_pc;
  logic [31:0]       mem_instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_pc, instr_valid, instr, instr_pc,
    input  mem_instr, instr_ready
  );

  modport slave (
    input  mem_pc, instr_valid, instr, instr_pc,
    output mem_instr, instr_ready
  );
endinterface

// File: rtl/fetch_out_slot.sv
// One-entry valid/ready output register: loads a fetched word, flushes on redirect,
// holds under back-pressure and empties itself once the word is consumed.
module fetch_out_slot #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       d_instr,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic              ready,
  output logic              valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              slot_free
);

  // Free when empty, or when the current word leaves at this edge.
  assign slot_free = !valid || ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      instr_pc <= d_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: walks mem_pc through instruction memory, hands words to decode
// through fetch_out_slot, and handles stall, redirect/flush and end-of-program halt.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_BYTES = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  inst_fetch_ctrl_if.master bus,
  output logic              halted,
  output logic              fetch_err,
  output logic [2:0]        dbg_state
);

  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - INSTR_BYTES);

  fetch_state_t      state;
  logic [ADDR_W-1:0] mem_pc_q;
  logic              slot_valid;
  logic              slot_free;
  logic              in_range;
  logic              redirect_ok;
  logic              active;
  logic              flush;
  logic              load;

  assign in_range    = pc_ok(64'(mem_pc_q), LAST_PC);
  assign redirect_ok = pc_ok(64'(redirect_pc), LAST_PC);
  assign active      = (state == ST_FETCH) || (state == ST_STALL) || (state == ST_DRAIN);

  // Redirect beats capture; a stalled word is re-offered from STALL the edge ready rises.
  assign flush = active && redirect_valid;
  assign load  = !flush &&
                 (((state == ST_FETCH) && in_range && slot_free) ||
                  ((state == ST_STALL) && bus.instr_ready));

  assign bus.mem_pc      = mem_pc_q;
  assign bus.instr_valid = slot_valid;
  assign dbg_state       = state;

  fetch_out_slot #(
    .ADDR_W (ADDR_W)
  ) u_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .flush     (flush),
    .d_instr   (bus.mem_instr),
    .d_pc      (mem_pc_q),
    .ready     (bus.instr_ready),
    .valid     (slot_valid),
    .instr     (bus.instr),
    .instr_pc  (bus.instr_pc),
    .slot_free (slot_free)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mem_pc_q  <= RESET_PC;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      if (load) begin
        mem_pc_q <= mem_pc_q + ADDR_W'(INSTR_BYTES);
      end
      if (flush) begin
        if (redirect_ok) begin
          mem_pc_q <= redirect_pc;
          state    <= ST_FETCH;
        end else begin
          fetch_err <= 1'b1;
          halted    <= 1'b1;
          state     <= ST_DONE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) state <= ST_FETCH;
          end
          ST_FETCH: begin
            if (in_range) begin
              if (!slot_free) state <= ST_STALL;
            end else if (slot_valid && !bus.instr_ready) begin
              state <= ST_DRAIN;
            end else begin
              halted <= 1'b1;
              state  <= ST_DONE;
            end
          end
          ST_STALL: begin
            if (bus.instr_ready) state <= ST_FETCH;
          end
          ST_DRAIN: begin
            if (bus.instr_ready) begin
              halted <= 1'b1;
              state  <= ST_DONE;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus randomized ready/redirect runs
// scored against a program-order model of which word decode must receive next.
module tb_inst_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fetch_err;
  logic [2:0]  dbg_state;

  int n_tests;
  int n_fail;

  inst_fetch_ctrl_if #(.ADDR_W(32)) bus ();

  inst_fetch_ctrl #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0),
    .MEM_BYTES (24)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .halted         (halted),
    .fetch_err      (fetch_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h00940333;
      32'h04:  return 32'h412983b3;
      32'h08:  return 32'h00f768b3;
      32'h0C:  return 32'h00d67fb3;
      32'h10:  return 32'h017b4e33;
      32'h14:  return 32'h01bdaf33;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.mem_instr = rom(bus.mem_pc);

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    start           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    bus.instr_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Returns just after the edge that sampled start: fetching begins, no word yet.
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(bus.instr_valid), 64'(1));
    check({tag, "_pc"},    64'(bus.instr_pc),    64'(pc));
    check({tag, "_instr"}, 64'(bus.instr),       64'(rom(pc)));
  endtask

  // ---------------- scoreboard for randomized runs ----------------
  logic [31:0] exp_q[$];

  task automatic random_run(input int run_id);
    logic [31:0] exp_pc;
    logic        err;
    logic        finished;
    logic        prev_hold;
    logic        expect_flush;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        redir;
    logic        bad;
    logic [31:0] target;
    logic [31:0] got_pc;

    do_reset();
    do_start();
    exp_pc       = 32'h0;
    err          = 1'b0;
    finished     = 1'b0;
    prev_hold    = 1'b0;
    expect_flush = 1'b0;
    prev_pc      = '0;
    prev_instr   = '0;
    exp_q.delete();

    for (int cyc = 0; cyc < 400; cyc++) begin
      // Done exactly when every word has been delivered, or after a bad redirect.
      check("rnd_halted", 64'(halted), 64'((exp_pc > 32'h14) || err));
      check("rnd_err", 64'(fetch_err), 64'(err));
      if (expect_flush) check("rnd_flush", 64'(bus.instr_valid), 64'(0));
      if (prev_hold) begin
        check("rnd_hold_valid", 64'(bus.instr_valid), 64'(1));
        check("rnd_hold_pc",    64'(bus.instr_pc),    64'(prev_pc));
        check("rnd_hold_instr", 64'(bus.instr),       64'(prev_instr));
      end
      if (halted) begin
        check("rnd_done_valid", 64'(bus.instr_valid), 64'(0));
        finished = 1'b1;
        break;
      end

      bus.instr_ready = ($urandom_range(0, 9) < 7);
      redir           = ($urandom_range(0, 9) == 0);
      bad             = 1'b0;
      target          = '0;
      if (redir) begin
        bad = ($urandom_range(0, 3) == 0);
        if (!bad) target = 32'(4 * $urandom_range(0, 5));
        else if ($urandom_range(0, 1) == 1) target = 32'(4 * $urandom_range(0, 5) + $urandom_range(1, 3));
        else target = 32'(24 + 4 * $urandom_range(0, 3));
      end
      redirect_valid = redir;
      redirect_pc    = target;

      if (bus.instr_valid && bus.instr_ready) begin
        exp_q.push_back(exp_pc);
        got_pc = exp_q.pop_front();
        check("rnd_hs_pc",    64'(bus.instr_pc), 64'(got_pc));
        check("rnd_hs_instr", 64'(bus.instr),    64'(rom(got_pc)));
        exp_pc = exp_pc + 32'd4;
      end
      prev_hold    = bus.instr_valid && !bus.instr_ready && !redir;
      prev_pc      = bus.instr_pc;
      prev_instr   = bus.instr;
      expect_flush = redir && !bad;
      if (redir) begin
        if (bad) err = 1'b1;
        else exp_pc = target;
      end

      step();
    end
    redirect_valid = 1'b0;
    if (!finished) begin
      $display("run %0d did not halt within its cycle budget", run_id);
      check("rnd_timeout", 64'(0), 64'(1));
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset values
    do_reset();
    check("rst_valid",  64'(bus.instr_valid), 64'(0));
    check("rst_mem_pc", 64'(bus.mem_pc),      64'(0));
    check("rst_instr",  64'(bus.instr),       64'(0));
    check("rst_pc",     64'(bus.instr_pc),    64'(0));
    check("rst_halted", 64'(halted),          64'(0));
    check("rst_err",    64'(fetch_err),       64'(0));

    // Redirect while idle is ignored and nothing fetches without start
    redirect_valid = 1'b1;
    redirect_pc    = 32'h06;
    step();
    redirect_valid = 1'b0;
    step();
    check("idle_err",   64'(fetch_err),       64'(0));
    check("idle_valid", 64'(bus.instr_valid), 64'(0));

    // 1. straight run, one word per cycle, halt after the last handshake
    bus.instr_ready = 1'b1;
    do_start();
    check("t1_lat", 64'(bus.instr_valid), 64'(0));
    step();
    for (int k = 0; k < 6; k++) begin
      check_word($sformatf("t1_w%0d", k), 32'(4 * k));
      check("t1_not_halted", 64'(halted), 64'(0));
      step();
    end
    check("t1_halted", 64'(halted),          64'(1));
    check("t1_valid0", 64'(bus.instr_valid), 64'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_sticky", 64'(halted),          64'(1));
    check("t1_valid1", 64'(bus.instr_valid), 64'(0));

    // 2. back-pressure holds the word and the fetch address
    do_reset();
    bus.instr_ready = 1'b1;
    do_start();
    step();
    step();
    check_word("t2_pre", 32'h04);
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_word("t2_hold", 32'h04);
      check("t2_mem_pc", 64'(bus.mem_pc), 64'(32'h08));
    end
    bus.instr_ready = 1'b1;
    step();
    check_word("t2_next", 32'h08);

    // 3. redirect flushes and restarts at the target
    do_reset();
    bus.instr_ready = 1'b1;
    do_start();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    check("t3_flush", 64'(bus.instr_valid), 64'(0));
    step();
    check_word("t3_w10", 32'h10);
    step();
    check_word("t3_w14", 32'h14);
    step();
    check("t3_halted", 64'(halted),    64'(1));
    check("t3_err",    64'(fetch_err), 64'(0));

    // 4. misaligned and out-of-range redirect targets
    for (int k = 0; k < 2; k++) begin
      do_reset();
      bus.instr_ready = 1'b1;
      do_start();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = (k == 0) ? 32'h06 : 32'h18;
      step();
      redirect_valid = 1'b0;
      check($sformatf("t4_err%0d", k),    64'(fetch_err),       64'(1));
      check($sformatf("t4_halted%0d", k), 64'(halted),          64'(1));
      check($sformatf("t4_valid%0d", k),  64'(bus.instr_valid), 64'(0));
    end

    // 5. last word held under back-pressure before halting
    do_reset();
    bus.instr_ready = 1'b1;
    do_start();
    step();
    repeat (5) step();
    check_word("t5_last", 32'h14);
    bus.instr_ready = 1'b0;
    step();
    check_word("t5_drain", 32'h14);
    check("t5_not_halted", 64'(halted), 64'(0));
    step();
    check("t5_still_open", 64'(halted), 64'(0));
    bus.instr_ready = 1'b1;
    step();
    check("t5_halted", 64'(halted),          64'(1));
    check("t5_valid",  64'(bus.instr_valid), 64'(0));

    // 6. reset mid-stream, then restart from the beginning
    do_reset();
    bus.instr_ready = 1'b1;
    do_start();
    step();
    repeat (3) step();
    check_word("t6_mid", 32'h0C);
    reset = 1'b0;
    step();
    check("t6_valid",  64'(bus.instr_valid), 64'(0));
    check("t6_mem_pc", 64'(bus.mem_pc),      64'(0));
    check("t6_instr",  64'(bus.instr),       64'(0));
    check("t6_pc",     64'(bus.instr_pc),    64'(0));
    check("t6_halted", 64'(halted),          64'(0));
    reset = 1'b1;
    do_start();
    step();
    check_word("t6_restart", 32'h00);

    // Randomized ready / redirect runs
    for (int r = 0; r < 20; r++) random_run(r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
